// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: checks fetch-time predictions against EX outcomes.
// Optional perf counters are built when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit #(
   parameter int QDEPTH       = 4,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        push_valid,
   input  logic [31:0] push_pc,
   input  logic        push_pred_taken,
   output logic        push_ready,
   input  logic        resolve_valid,
   input  logic        resolve_is_branch,
   input  logic        resolve_taken,
   input  logic [31:0] resolve_target,
   output logic [31:0] upd_pc,
   output logic        upd_is_branch,
   output logic        upd_is_taken,
   output logic        flush,
   output logic [31:0] redirect_pc,
   output logic        queue_empty,
`ifdef BRU_PERF_CNT_EN
   output logic [31:0] br_count,
   output logic [31:0] mispred_count,
`endif
   output logic        err_underflow
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;
   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam logic [CW-1:0] FULL  = CW'(QDEPTH);
   localparam logic [FW-1:0] FLOAD = FW'(FLUSH_CYCLES - 1);
   localparam logic [0:0] S_RUN   = 1'b0;
   localparam logic [0:0] S_FLUSH = 1'b1;

   logic [0:0]    state;
   logic [FW-1:0] fcnt;
   logic [PW-1:0] wptr;
   logic [PW-1:0] rptr;
   logic [CW-1:0] count;
   logic [31:0]   q_pc [QDEPTH];
   logic [QDEPTH-1:0] q_pred;

   logic        run;
   logic        push_fire;
   logic        pop;
   logic        act_taken;
   logic        mispred;
   logic [31:0] head_pc;
   logic        head_pred;
   logic [31:0] next_pc;

   assign run         = (state == S_RUN);
   assign push_ready  = (count != FULL) && run;
   assign queue_empty = (count == '0);
   assign push_fire   = push_valid && push_ready;
   assign pop         = resolve_valid && run && (count != '0);
   assign head_pc     = q_pc[rptr];
   assign head_pred   = q_pred[rptr];
   assign act_taken   = resolve_is_branch && resolve_taken;
   assign mispred     = pop && (head_pred != act_taken);
   assign next_pc     = act_taken ? resolve_target : head_pc + 32'd4;

   // Storage needs no reset; a push racing a mispredict is discarded.
   always_ff @(posedge clk) begin
      if (push_fire && !mispred) begin
         q_pc[wptr]   <= push_pc;
         q_pred[wptr] <= push_pred_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_RUN;
         fcnt          <= '0;
         wptr          <= '0;
         rptr          <= '0;
         count         <= '0;
         upd_pc        <= '0;
         upd_is_branch <= 1'b0;
         upd_is_taken  <= 1'b0;
         flush         <= 1'b0;
         redirect_pc   <= '0;
         err_underflow <= 1'b0;
      end else begin
         if (mispred) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            state <= S_FLUSH;
            fcnt  <= FLOAD;
         end else begin
            if (push_fire) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push_fire && !pop) count <= count + 1'b1;
            else if (pop && !push_fire) count <= count - 1'b1;
            if (state == S_FLUSH) begin
               if (fcnt == '0) state <= S_RUN;
               else fcnt <= fcnt - 1'b1;
            end
         end
         upd_pc        <= pop ? head_pc : '0;
         upd_is_branch <= pop && resolve_is_branch;
         upd_is_taken  <= pop && resolve_taken;
         flush         <= mispred;
         redirect_pc   <= mispred ? next_pc : '0;
         if (resolve_valid && run && (count == '0)) err_underflow <= 1'b1;
      end
   end

`ifdef BRU_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         br_count      <= '0;
         mispred_count <= '0;
      end else begin
         if (pop && resolve_is_branch) br_count <= br_count + 32'd1;
         if (mispred) mispred_count <= mispred_count + 32'd1;
      end
   end
`endif

endmodule
